// File: rtl/io_mmio.sv
// io_mmio: memory-mapped I/O block with an LED register, a debounced 4-bit
// switch input, a free-running 32-bit timer with compare match, a sticky
// status register with write-1-to-clear bits, and a level interrupt output.
//
// Register window (byte offsets from BASE_ADDR, word granular):
//   0x00 LED    RW [7:0]
//   0x04 SW     RO [3:0]   debounced switch levels
//   0x08 COUNT  RW [31:0]
//   0x0C CMP    RW [31:0]
//   0x10 STATUS RW1C [1:0] [0] timer match, [1] switch change
//   0x14 CTRL   RW [3:0]   [0] timer en, [1] auto-clear, [2] irq en match,
//                          [3] irq en switch change
//   0x18/0x1C reserved, read as zero

module io_mmio #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_1000,
    parameter int                    DEBOUNCE_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic [3:0]            i_sw,
    output logic [7:0]            o_led,
    output logic                  o_irq
);

    localparam logic [2:0]  OFF_LED    = 3'd0;
    localparam logic [2:0]  OFF_SW     = 3'd1;
    localparam logic [2:0]  OFF_COUNT  = 3'd2;
    localparam logic [2:0]  OFF_CMP    = 3'd3;
    localparam logic [2:0]  OFF_STATUS = 3'd4;
    localparam logic [2:0]  OFF_CTRL   = 3'd5;
    localparam logic [15:0] DEB_LIMIT  = 16'(DEBOUNCE_CYCLES);

    // Architectural registers
    logic [7:0]  led_q,    led_d;
    logic [3:0]  sw_q,     sw_d;
    logic [31:0] count_q,  count_d;
    logic [31:0] cmp_q,    cmp_d;
    logic [1:0]  status_q, status_d;
    logic [3:0]  ctrl_q,   ctrl_d;
    logic        irq_q,    irq_d;

    // Switch synchronizer and debounce state
    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  sync_prev_q;
    logic [15:0] stab_cnt_q, stab_cnt_d;

    // Decode and event strobes
    logic        sel_s;
    logic [2:0]  off_s;
    logic        wr_s;
    logic        match_s;
    logic        sw_set_s;
    logic [15:0] stab_next_s;
    logic [1:0]  clr_s;
    logic        unused_s;

    assign sel_s    = (i_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign off_s    = i_addr[4:2];
    assign wr_s     = i_we & sel_s;
    assign unused_s = &{1'b0, i_addr[1:0]};

    // Read mux: combinational, no side effects, zero for reserved/unselected
    always_comb begin
        o_rdata = 32'h0000_0000;
        if (sel_s) begin
            case (off_s)
                OFF_LED:    o_rdata = {24'h00_0000, led_q};
                OFF_SW:     o_rdata = {28'h000_0000, sw_q};
                OFF_COUNT:  o_rdata = count_q;
                OFF_CMP:    o_rdata = cmp_q;
                OFF_STATUS: o_rdata = {30'h0000_0000, status_q};
                OFF_CTRL:   o_rdata = {28'h000_0000, ctrl_q};
                default:    o_rdata = 32'h0000_0000;
            endcase
        end else begin
            o_rdata = 32'h0000_0000;
        end
    end

    // Debounce: count consecutive cycles the synchronized value is stable and
    // differs from SW; a change of the synchronized value restarts at one.
    always_comb begin
        sw_d        = sw_q;
        sw_set_s    = 1'b0;
        stab_cnt_d  = 16'd0;
        stab_next_s = (sync2_q != sync_prev_q) ? 16'd1 : (stab_cnt_q + 16'd1);
        if (sync2_q == sw_q) begin
            stab_cnt_d = 16'd0;
        end else if (stab_next_s == DEB_LIMIT) begin
            sw_d       = sync2_q;
            sw_set_s   = 1'b1;
            stab_cnt_d = 16'd0;
        end else begin
            stab_cnt_d = stab_next_s;
        end
    end

    // Timer: CPU write wins over increment/auto-clear; match uses the
    // pre-write COUNT so a freshly written value is compared next cycle.
    always_comb begin
        match_s = ctrl_q[0] & (count_q == cmp_q);
        count_d = count_q;
        if (wr_s && (off_s == OFF_COUNT)) begin
            count_d = i_wdata[31:0];
        end else if (ctrl_q[0]) begin
            if (match_s && ctrl_q[1]) begin
                count_d = 32'h0000_0000;
            end else begin
                count_d = count_q + 32'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Simple RW registers and sticky status (hardware set beats W1C clear)
    always_comb begin
        led_d  = led_q;
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        clr_s  = 2'b00;
        if (wr_s) begin
            case (off_s)
                OFF_LED:    led_d  = i_wdata[7:0];
                OFF_CMP:    cmp_d  = i_wdata[31:0];
                OFF_STATUS: clr_s  = i_wdata[1:0];
                OFF_CTRL:   ctrl_d = i_wdata[3:0];
                default:    clr_s  = 2'b00;
            endcase
        end else begin
            clr_s = 2'b00;
        end
        status_d = (status_q & ~clr_s) | {sw_set_s, match_s};
        irq_d    = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
    end

    // Switch synchronizer chain plus the previous-sample flop for debounce
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_q     <= 4'h0;
            sync2_q     <= 4'h0;
            sync_prev_q <= 4'h0;
        end else begin
            sync1_q     <= i_sw;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    // Register state update
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            led_q      <= 8'h00;
            sw_q       <= 4'h0;
            stab_cnt_q <= 16'd0;
            count_q    <= 32'h0000_0000;
            cmp_q      <= 32'h0000_0000;
            status_q   <= 2'b00;
            ctrl_q     <= 4'h0;
            irq_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            sw_q       <= sw_d;
            stab_cnt_q <= stab_cnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            status_q   <= status_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    assign o_led = led_q;
    assign o_irq = irq_q;

endmodule

// File: tb/tb_io_mmio.sv
// Directed self-checking bench for io_mmio (DEBOUNCE_CYCLES = 4).
module tb_io_mmio;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_LED  = BASE + 32'h00;
    localparam logic [31:0] A_SW   = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [31:0] A_CTRL = BASE + 32'h14;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_addr;
    logic        i_we;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic [3:0]  i_sw;
    logic [7:0]  o_led;
    logic        o_irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] d;

    io_mmio #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .BASE_ADDR       (32'h0000_1000),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_addr  (i_addr),
        .i_we    (i_we),
        .i_wdata (i_wdata),
        .o_rdata (o_rdata),
        .i_sw    (i_sw),
        .o_led   (o_led),
        .o_irq   (o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write, taking effect on the next rising edge; returns 1ns after it
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge i_clk);
        i_addr  = a;
        i_wdata = v;
        i_we    = 1'b1;
        @(posedge i_clk);
        #1;
        i_we    = 1'b0;
        i_addr  = 32'h0000_0000;
        i_wdata = 32'h0000_0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        i_addr = a;
        #1;
        v = o_rdata;
        i_addr = 32'h0000_0000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst   = 1'b0;
        i_addr  = 32'h0000_0000;
        i_we    = 1'b0;
        i_wdata = 32'h0000_0000;
        i_sw    = 4'h0;
        #1;
        chk("rst_led", {24'h0, o_led}, 32'h0);
        chk("rst_irq", {31'h0, o_irq}, 32'h0);
        rd(A_CNT, d);  chk("rst_count", d, 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        step(1);

        // LED write/readback, reserved and unselected accesses
        wr(A_LED, 32'h0000_00A5);
        chk("led_out", {24'h0, o_led}, 32'h0000_00A5);
        rd(A_LED, d);            chk("led_rd", d, 32'h0000_00A5);
        rd(BASE + 32'h3, d);     chk("led_rd_bytelane", d, 32'h0000_00A5);
        rd(BASE + 32'h1C, d);    chk("rsvd_1c", d, 32'h0);
        rd(BASE + 32'h18, d);    chk("rsvd_18", d, 32'h0);
        wr(BASE + 32'h40, 32'hFFFF_FFFF);
        chk("unsel_led", {24'h0, o_led}, 32'h0000_00A5);
        rd(BASE + 32'h40, d);    chk("unsel_rd", d, 32'h0);
        rd(A_CNT, d);            chk("unsel_cnt", d, 32'h0);
        rd(A_CTRL, d);           chk("unsel_ctrl", d, 32'h0);
        wr(A_SW, 32'h0000_000F);
        rd(A_SW, d);             chk("sw_ro", d, 32'h0);
        wr(A_CMP, 32'h1234_5678);
        rd(A_CMP, d);            chk("cmp_rw", d, 32'h1234_5678);

        // Debounce: 2 sync + 4 stable cycles
        step(1);
        i_sw = 4'b0101;
        step(5);
        rd(A_SW, d);             chk("sw_early", d, 32'h0);
        step(1);
        rd(A_SW, d);             chk("sw_update", d, 32'h5);
        rd(A_STAT, d);           chk("stat_swchg", d, 32'h2);
        wr(A_CTRL, 32'h8);
        chk("irq_sw_lat0", {31'h0, o_irq}, 32'h0);
        step(1);
        chk("irq_sw_on", {31'h0, o_irq}, 32'h1);
        wr(A_CTRL, 32'h0);
        chk("irq_sw_hold", {31'h0, o_irq}, 32'h1);
        step(1);
        chk("irq_sw_off", {31'h0, o_irq}, 32'h0);

        // 3-cycle glitch must be rejected
        step(1);
        i_sw = 4'b1010;
        step(3);
        i_sw = 4'b0101;
        step(10);
        rd(A_SW, d);             chk("glitch_sw", d, 32'h5);
        rd(A_STAT, d);           chk("glitch_stat", d, 32'h2);
        wr(A_STAT, 32'h3);
        rd(A_STAT, d);           chk("stat_w1c", d, 32'h0);

        // Match with auto-clear and interrupt
        wr(A_CMP, 32'h5);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h7);
        rd(A_CNT, d);            chk("tm_start", d, 32'h0);
        step(5);
        rd(A_CNT, d);            chk("tm_cnt5", d, 32'h5);
        rd(A_STAT, d);           chk("tm_nomatch_yet", d, 32'h0);
        step(1);
        rd(A_STAT, d);           chk("tm_match", d, 32'h1);
        rd(A_CNT, d);            chk("tm_autoclr", d, 32'h0);
        chk("tm_irq_lat", {31'h0, o_irq}, 32'h0);
        step(1);
        chk("tm_irq_on", {31'h0, o_irq}, 32'h1);
        wr(A_STAT, 32'h1);
        rd(A_STAT, d);           chk("tm_stat_clr", d, 32'h0);
        chk("tm_irq_hold", {31'h0, o_irq}, 32'h1);
        step(1);
        chk("tm_irq_off", {31'h0, o_irq}, 32'h0);

        // Wrap-around with no flag before COUNT==3
        wr(A_CTRL, 32'h0);
        wr(A_CMP, 32'h3);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, d);            chk("wrap_fffe", d, 32'hFFFF_FFFE);
        step(1);
        rd(A_CNT, d);            chk("wrap_ffff", d, 32'hFFFF_FFFF);
        step(1);
        rd(A_CNT, d);            chk("wrap_0", d, 32'h0);
        step(1);
        rd(A_CNT, d);            chk("wrap_1", d, 32'h1);
        step(2);
        rd(A_CNT, d);            chk("wrap_3", d, 32'h3);
        rd(A_STAT, d);           chk("wrap_nostat", d, 32'h0);
        step(1);
        rd(A_STAT, d);           chk("wrap_match", d, 32'h1);
        rd(A_CNT, d);            chk("wrap_4", d, 32'h4);

        // Same-cycle clear and match: set wins; COUNT write overrides
        wr(A_CNT, 32'h2);
        rd(A_CNT, d);            chk("ovr_cnt2", d, 32'h2);
        step(1);
        wr(A_STAT, 32'h1);
        rd(A_STAT, d);           chk("set_beats_clr", d, 32'h1);
        rd(A_CNT, d);            chk("after_match_cnt", d, 32'h4);
        wr(A_CNT, 32'h10);
        rd(A_CNT, d);            chk("cnt_write_10", d, 32'h10);
        step(1);
        rd(A_CNT, d);            chk("cnt_inc_11", d, 32'h11);
        wr(A_STAT, 32'h1);
        rd(A_STAT, d);           chk("clr_no_match", d, 32'h0);

        // Asynchronous reset mid-operation
        wr(A_CTRL, 32'h0);
        wr(A_LED, 32'hFFFF_FFFF);
        rd(A_LED, d);            chk("led_upper0", d, 32'h0000_00FF);
        wr(A_CNT, 32'h20);
        wr(A_CMP, 32'h20);
        wr(A_CTRL, 32'h5);
        step(1);
        rd(A_STAT, d);           chk("pre_rst_stat", d, 32'h1);
        step(1);
        chk("pre_rst_irq", {31'h0, o_irq}, 32'h1);
        #1;
        i_rst = 1'b0;
        i_sw  = 4'h0;
        #1;
        chk("arst_led", {24'h0, o_led}, 32'h0);
        chk("arst_irq", {31'h0, o_irq}, 32'h0);
        rd(A_CNT, d);            chk("arst_cnt", d, 32'h0);
        rd(A_SW, d);             chk("arst_sw", d, 32'h0);
        step(3);
        @(negedge i_clk);
        i_rst = 1'b1;
        step(5);
        rd(A_CNT, d);            chk("post_rst_cnt", d, 32'h0);
        rd(A_CTRL, d);           chk("post_rst_ctrl", d, 32'h0);
        rd(A_STAT, d);           chk("post_rst_stat", d, 32'h0);
        rd(A_CMP, d);            chk("post_rst_cmp", d, 32'h0);
        chk("post_rst_led", {24'h0, o_led}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
